cpu_player_ctrl: RTL and testbench



---
 rtl/tow_pkg.sv | 24 ++
 rtl/lfsr10.sv | 37 +++
 rtl/cpu_player_ctrl.sv | 116 +++++++++++
 tb/tb_cpu_player_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and constants for the Tug-of-War computer opponent.
// Holds operand width, controller states and LFSR taps.
package tow_pkg;

    localparam int WIDTH       = 10;
    localparam int LFSR_TAP_HI = 9;
    localparam int LFSR_TAP_LO = 6;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESS,
        COOL
    } cpu_state_t;

    // Fibonacci step for x^10 + x^7 + 1
    function automatic logic [WIDTH-1:0] lfsr_next(
        input logic [WIDTH-1:0] q
    );
        return {q[WIDTH-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit maximal-length LFSR supplying pseudo-random comparator operands.
// Advances only when step is high; load_seed forces the seed value.
module lfsr10
    import tow_pkg::*;
#(
    parameter logic [WIDTH-1:0] SEED = 10'h001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_seed,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_seed) begin
            q_d = SEED;
        end else if (step) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/cpu_player_ctrl.sv
// Computer opponent: drives difficulty and LFSR onto an external registered
// comparator and emits a one-cycle press whenever difficulty > LFSR.
module cpu_player_ctrl
    import tow_pkg::*;
#(
    parameter int               COOLDOWN  = 4,
    parameter logic [WIDTH-1:0] LFSR_SEED = 10'h001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] difficulty,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             cmp_gt,
    output logic             press,
    output logic             busy,
    output logic [7:0]       press_count
);

    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN - 1);

    cpu_state_t       state_q, state_d;
    logic [WIDTH-1:0] cmp_a_q, cmp_a_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       count_q, count_d;
    logic             press_q, press_d;
    logic             step;
    logic             enter_issue;
    logic [WIDTH-1:0] lfsr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enter_issue = 1'b0;
        count_d     = count_q;
        if (state_q == PRESS && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (cmp_gt) begin
                    state_d = PRESS;
                end else begin
                    state_d     = ISSUE;
                    enter_issue = 1'b1;
                end
            end
            PRESS: begin
                state_d = COOL;
                cnt_d   = COOL_LOAD;
            end
            COOL: begin
                if (cnt_q == '0) begin
                    state_d     = ISSUE;
                    enter_issue = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Pausing drops any pending press and leaves the LFSR where it was
        if (!enable && state_q != IDLE) begin
            state_d     = IDLE;
            cnt_d       = '0;
            enter_issue = 1'b0;
        end
        step    = enter_issue;
        cmp_a_d = cmp_a_q;
        if (enter_issue || (state_q == IDLE && enable)) begin
            cmp_a_d = difficulty;
        end
        press_d = (state_d == PRESS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cmp_a_q <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmp_a_q <= cmp_a_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            press_q <= press_d;
        end
    end

    lfsr10 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load_seed(lfsr_q == '0),
        .step     (step),
        .q        (lfsr_q)
    );

    assign cmp_a       = cmp_a_q;
    assign cmp_b       = lfsr_q;
    assign press       = press_q;
    assign busy        = (state_q != IDLE);
    assign press_count = count_q;

endmodule

// File: tb/tb_cpu_player_ctrl.sv
// Directed bench for cpu_player_ctrl with a registered 10-bit comparator.
module tb_cpu_player_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] difficulty;
    logic [9:0] cmp_a;
    logic [9:0] cmp_b;
    logic       cmp_gt = 1'b0;
    logic       press;
    logic       busy;
    logic [7:0] press_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) cmp_gt <= (cmp_a > cmp_b);

    cpu_player_ctrl #(
        .COOLDOWN (4),
        .LFSR_SEED(10'h001)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .difficulty (difficulty),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .cmp_gt     (cmp_gt),
        .press      (press),
        .busy       (busy),
        .press_count(press_count)
    );

    typedef struct {
        logic [9:0] lfsr;
        logic       press;
    } dec_t;

    dec_t vec [11];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its first ISSUE cycle
    task automatic do_reset(input logic [9:0] diff);
        reset      = 1'b1;
        enable     = 1'b1;
        difficulty = diff;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int first;
        int zeros;
        int presses;
        bit found;

        vec[0]  = '{10'h001, 1'b1};
        vec[1]  = '{10'h002, 1'b1};
        vec[2]  = '{10'h004, 1'b1};
        vec[3]  = '{10'h008, 1'b1};
        vec[4]  = '{10'h010, 1'b1};
        vec[5]  = '{10'h020, 1'b1};
        vec[6]  = '{10'h040, 1'b0};
        vec[7]  = '{10'h081, 1'b0};
        vec[8]  = '{10'h102, 1'b0};
        vec[9]  = '{10'h204, 1'b0};
        vec[10] = '{10'h009, 1'b1};

        reset      = 1'b1;
        enable     = 1'b1;
        difficulty = 10'h030;
        #2;
        chk("rst_press", press, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmp_b", cmp_b, 10'h001);
        chk("rst_cmp_a", cmp_a, 0);
        chk("rst_count", press_count, 0);
        tick();
        reset = 1'b0;
        chk("rel_busy0", busy, 0);
        tick();
        chk("rel_busy1", busy, 1);
        chk("issue_cmp_a", cmp_a, 10'h030);

        for (int i = 0; i < 11; i++) begin
            chk($sformatf("dec%0d_cmp_b", i), cmp_b, vec[i].lfsr);
            chk($sformatf("dec%0d_issue_press", i), press, 0);
            tick();
            tick();
            chk($sformatf("dec%0d_press", i), press, vec[i].press);
            if (vec[i].press) begin
                for (int c = 0; c < 5; c++) begin
                    tick();
                    chk($sformatf("dec%0d_cool%0d", i, c), press, 0);
                end
            end
        end
        chk("basic_count", press_count, 7);

        do_reset(10'h000);
        first   = 0;
        zeros   = 0;
        presses = 0;
        for (int k = 1; k < 3000; k++) begin
            tick();
            if (cmp_b == 10'h000) zeros++;
            if (press) presses++;
            if (cmp_b == 10'h001 && k > 1 && first == 0) first = k;
        end
        chk("d0_presses", presses, 0);
        chk("d0_zero_lfsr", zeros, 0);
        chk("d0_period", first, 2046);
        chk("d0_count", press_count, 0);

        do_reset(10'h030);
        tick();
        tick();
        chk("pause_press", press, 1);
        tick();
        enable = 1'b0;
        tick();
        chk("pause_busy", busy, 0);
        chk("pause_lfsr", cmp_b, 10'h001);
        tick();
        chk("pause_hold", cmp_b, 10'h001);
        enable = 1'b1;
        tick();
        chk("resume_busy", busy, 1);
        chk("resume_cmp_b", cmp_b, 10'h001);
        tick();
        chk("resume_wait_b", cmp_b, 10'h001);
        tick();
        chk("resume_press", press, 1);
        repeat (5) tick();
        chk("resume_next_b", cmp_b, 10'h002);

        do_reset(10'h3FF);
        chk("late_cmp_a", cmp_a, 10'h3FF);
        tick();
        difficulty = 10'h000;
        tick();
        chk("late_press", press, 1);
        chk("late_hold_a", cmp_a, 10'h3FF);
        repeat (5) tick();
        chk("late_new_a", cmp_a, 10'h000);
        chk("late_new_b", cmp_b, 10'h002);

        do_reset(10'h3FF);
        repeat (2000) tick();
        chk("sat_count", press_count, 255);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (press) found = 1'b1;
        end
        chk("async_found", found, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_press", press, 0);
        chk("async_busy", busy, 0);
        chk("async_count", press_count, 0);
        tick();
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
